// File: rtl/soc_reset_pkg.sv
// Shared reset-sequencing definitions: sequencer state encoding and default cycle budgets.
package soc_reset_pkg;

    typedef enum logic [2:0] {
        PLL_RST   = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAIL      = 3'd4
    } seq_state_t;

    localparam int DEF_PLL_RST_CYCLES      = 16;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_MAX_RETRIES         = 7;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer with synchronous active-low reset.
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic meta;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end
endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL bring-up sequencer: pulses the PLL reset, waits for a continuously stable lock,
// then releases the system reset; retries on lock timeout and gives up after MAX_RETRIES.
module pll_reset_sequencer
    import soc_reset_pkg::*;
#(
    parameter int PLL_RST_CYCLES      = DEF_PLL_RST_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       locked_in,
    input  logic       soft_reset_req,
    output logic       pll_rst,
    output logic       sys_reset_n,
    output logic       ready,
    output logic       fail,
    output logic [7:0] retry_count,
    output logic [7:0] lock_loss_count,
    output logic [2:0] state_dbg
);
    localparam int MAX_CYC = max3(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    localparam logic [CNT_W-1:0] RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [7:0]       RETRY_LIMIT  = 8'(MAX_RETRIES);

    seq_state_t       state, state_next;
    logic [CNT_W-1:0] cnt;
    logic             cnt_clr;
    logic [7:0]       retry_next, loss_next;
    logic             locked_s;

    sync_2ff u_lock_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (locked_in),
        .q       (locked_s)
    );

    assign state_dbg = state;

    always_comb begin
        state_next = state;
        retry_next = retry_count;
        loss_next  = lock_loss_count;
        cnt_clr    = 1'b0;
        case (state)
            PLL_RST: if (cnt == RST_LAST) state_next = WAIT_LOCK;
            WAIT_LOCK: begin
                // Lock seen on the timeout cycle takes priority over counting a retry.
                if (locked_s) begin
                    state_next = STABLE;
                end else if (cnt == TIMEOUT_LAST) begin
                    retry_next = retry_count + 8'd1;
                    state_next = (retry_next == RETRY_LIMIT) ? FAIL : PLL_RST;
                end
            end
            STABLE: begin
                if (!locked_s)                state_next = WAIT_LOCK;
                else if (cnt == STABLE_LAST)  state_next = RUN;
            end
            RUN: begin
                if (!locked_s) begin
                    if (lock_loss_count != 8'hFF) loss_next = lock_loss_count + 8'd1;
                    state_next = PLL_RST;
                end
            end
            FAIL:    state_next = FAIL;
            default: state_next = PLL_RST;
        endcase
        // A soft request restarts the attempt but keeps any lock-loss just recorded.
        if (soft_reset_req) begin
            state_next = PLL_RST;
            retry_next = 8'd0;
        end
        if (state_next == RUN && state != RUN) retry_next = 8'd0;
        cnt_clr = soft_reset_req || (state_next != state);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state           <= PLL_RST;
            cnt             <= '0;
            retry_count     <= 8'd0;
            lock_loss_count <= 8'd0;
            pll_rst         <= 1'b1;
            sys_reset_n     <= 1'b0;
            ready           <= 1'b0;
            fail            <= 1'b0;
        end else begin
            state           <= state_next;
            cnt             <= cnt_clr ? '0 : cnt + 1'b1;
            retry_count     <= retry_next;
            lock_loss_count <= loss_next;
            pll_rst         <= (state_next == PLL_RST);
            sys_reset_n     <= (state_next == RUN);
            ready           <= (state_next == RUN);
            fail            <= (state_next == FAIL);
        end
    end
endmodule
